// File: rtl/sys_bus_arb_pkg.sv
// Shared types and the round-robin selection rule for the simple-bus arbiter.
package sys_bus_arb_pkg;

   localparam int unsigned MAX_N = 8;
   localparam int unsigned LW    = 3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_t;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } req_type_t;

   // First requester after `last` in circular order over n slots; returns `last` when none request.
   function automatic logic [LW-1:0] rr_next(input logic [MAX_N-1:0] req,
                                             input logic [LW-1:0]    last,
                                             input int unsigned      n);
      logic [LW-1:0] idx;
      int unsigned   cand;
      idx  = last;
      cand = 0;
      for (int unsigned k = MAX_N; k >= 1; k--) begin
         if (k <= n) begin
            cand = (32'(last) + k) % n;
            if (req[LW'(cand)]) begin
               idx = LW'(cand);
            end
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest distance after `last_i` among set request bits.
module rr_arbiter
   import sys_bus_arb_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]          req_i,
   input  logic [$clog2(N)-1:0]  last_i,
   output logic [$clog2(N)-1:0]  gnt_idx_c_o,
   output logic [N-1:0]          gnt_oh_c_o,
   output logic                  any_c_o
);

   localparam int unsigned IW = $clog2(N);

   logic [LW-1:0] pick;

   always_comb begin
      pick        = rr_next(MAX_N'(req_i), LW'(last_i), N);
      gnt_idx_c_o = IW'(pick);
      gnt_oh_c_o  = '0;
      if (|req_i) begin
         gnt_oh_c_o[gnt_idx_c_o] = 1'b1;
      end
   end

   assign any_c_o = |req_i;

endmodule

// File: rtl/sys_bus_arbiter.sv
// N-master to one-slave simple-bus arbiter: latches strobes as pending requests,
// issues them one at a time in round-robin order and routes ack/data back.
module sys_bus_arbiter
   import sys_bus_arb_pkg::*;
#(
   parameter int unsigned N   = 2,
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned TMO = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N-1:0]      s_wen,
   input  logic [N-1:0]      s_ren,
   input  logic [N*AW-1:0]   s_addr,
   input  logic [N*DW-1:0]   s_wdata,
   output logic [N-1:0]      s_ack,
   output logic [N-1:0]      s_err,
   output logic [DW-1:0]     s_rdata,
   output logic [N-1:0]      s_ovf,
   output logic              m_wen,
   output logic              m_ren,
   output logic [AW-1:0]     m_addr,
   output logic [DW-1:0]     m_wdata,
   input  logic [DW-1:0]     m_rdata,
   input  logic              m_ack
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned TW = $clog2(TMO);

   arb_state_t    state_q, state_d;
   logic [N-1:0]  pend_q, pend_d;
   logic [N-1:0]  ovf_q, ovf_d;
   logic [AW-1:0] addr_q  [N];
   logic [AW-1:0] addr_d  [N];
   logic [DW-1:0] wdata_q [N];
   logic [DW-1:0] wdata_d [N];
   req_type_t     type_q  [N];
   req_type_t     type_d  [N];
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] gidx_q, gidx_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [N-1:0]  s_ack_q, s_ack_d;
   logic [N-1:0]  s_err_q, s_err_d;
   logic [DW-1:0] s_rdata_q, s_rdata_d;
   logic          m_wen_q, m_wen_d;
   logic          m_ren_q, m_ren_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;

   logic [IW-1:0] gnt_idx_c;
   logic [N-1:0]  gnt_oh_c;
   logic          any_c;
   logic          grant_c;

   rr_arbiter #(
      .N (N)
   ) u_rr (
      .req_i       (pend_q),
      .last_i      (last_q),
      .gnt_idx_c_o (gnt_idx_c),
      .gnt_oh_c_o  (gnt_oh_c),
      .any_c_o     (any_c)
   );

   assign grant_c = (state_q == IDLE) && any_c;

   // Pending capture: a same-edge grant frees the slot, so a new strobe then wins without overflow.
   always_comb begin
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      type_d  = type_q;
      for (int i = 0; i < N; i++) begin
         if (s_wen[i] || s_ren[i]) begin
            if (pend_q[i] && !(grant_c && gnt_oh_c[i])) begin
               ovf_d[i] = 1'b1;
            end else begin
               pend_d[i]  = 1'b1;
               addr_d[i]  = s_addr[i*AW +: AW];
               wdata_d[i] = s_wdata[i*DW +: DW];
               type_d[i]  = s_wen[i] ? WR : RD;
            end
         end else if (grant_c && gnt_oh_c[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // Transfer FSM: issue in IDLE, wait for ack or timeout in WAIT.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gidx_d    = gidx_q;
      timer_d   = timer_q;
      s_ack_d   = '0;
      s_err_d   = '0;
      s_rdata_d = s_rdata_q;
      m_wen_d   = 1'b0;
      m_ren_d   = 1'b0;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_c) begin
               gidx_d    = gnt_idx_c;
               last_d    = gnt_idx_c;
               m_addr_d  = addr_q[gnt_idx_c];
               m_wdata_d = wdata_q[gnt_idx_c];
               if (type_q[gnt_idx_c] == WR) begin
                  m_wen_d = 1'b1;
               end else begin
                  m_ren_d = 1'b1;
               end
               timer_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (m_ack) begin
               s_ack_d[gidx_q] = 1'b1;
               s_rdata_d       = m_rdata;
               state_d         = IDLE;
            end else if (timer_q == TW'(TMO - 1)) begin
               s_ack_d[gidx_q] = 1'b1;
               s_err_d[gidx_q] = 1'b1;
               s_rdata_d       = '0;
               state_d         = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         pend_q    <= '0;
         ovf_q     <= '0;
         last_q    <= IW'(N - 1);
         gidx_q    <= '0;
         timer_q   <= '0;
         s_ack_q   <= '0;
         s_err_q   <= '0;
         s_rdata_q <= '0;
         m_wen_q   <= 1'b0;
         m_ren_q   <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         for (int i = 0; i < N; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            type_q[i]  <= RD;
         end
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         last_q    <= last_d;
         gidx_q    <= gidx_d;
         timer_q   <= timer_d;
         s_ack_q   <= s_ack_d;
         s_err_q   <= s_err_d;
         s_rdata_q <= s_rdata_d;
         m_wen_q   <= m_wen_d;
         m_ren_q   <= m_ren_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         type_q    <= type_d;
      end
   end

   assign s_ack   = s_ack_q;
   assign s_err   = s_err_q;
   assign s_rdata = s_rdata_q;
   assign s_ovf   = ovf_q;
   assign m_wen   = m_wen_q;
   assign m_ren   = m_ren_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

endmodule
